// File: rtl/ws2812_encoder_pkg.sv
// Shared timing defaults and encoder state encoding for the WS2812 serial encoder.
package pipeline_types;

    localparam int T0H_CYC_DEF    = 20;
    localparam int T1H_CYC_DEF    = 40;
    localparam int TBIT_CYC_DEF   = 63;
    localparam int TRESET_CYC_DEF = 2500;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW,
        ST_LATCH
    } enc_state_t;

endpackage

// File: rtl/ws2812_encoder_if.sv
// Load/done link between the encoder FSM (master) and its shared phase timer (slave).
interface ws2812_encoder_if #(
    parameter int CNT_W = 12
);
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             done;

    modport master (output load, output load_val, input done);
    modport slave  (input load, input load_val, output done);
endinterface

// File: rtl/ws2812_phase_timer.sv
// Loadable down-counter; done is high while the count sits at zero, so a load of N-1 spans N cycles.
module ws2812_phase_timer #(
    parameter int CNT_W = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ws2812_encoder_if.slave         tmr
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tmr.load) begin
            cnt <= tmr.load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tmr.done = (cnt == '0);

endmodule

// File: rtl/ws2812_encoder.sv
// WS2812 pixel encoder: serialises 24-bit GRB words MSB first and inserts latch gaps on request.
module ws2812_encoder
    import pipeline_types::*;
#(
    parameter int T0H_CYC    = T0H_CYC_DEF,
    parameter int T1H_CYC    = T1H_CYC_DEF,
    parameter int TBIT_CYC   = TBIT_CYC_DEF,
    parameter int TRESET_CYC = TRESET_CYC_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [23:0] i_pixel,
    input  logic        i_pixel_valid,
    output logic        o_pixel_ready,
    input  logic        i_latch,
    output logic        o_dout,
    output logic        o_busy
);

    localparam int CNT_MAX = (TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    // Timer load values are one less than the phase length.
    localparam logic [CNT_W-1:0] T0H_LD  = CNT_W'(T0H_CYC - 1);
    localparam logic [CNT_W-1:0] T1H_LD  = CNT_W'(T1H_CYC - 1);
    localparam logic [CNT_W-1:0] T0L_LD  = CNT_W'(TBIT_CYC - T0H_CYC - 1);
    localparam logic [CNT_W-1:0] T1L_LD  = CNT_W'(TBIT_CYC - T1H_CYC - 1);
    localparam logic [CNT_W-1:0] TRST_LD = CNT_W'(TRESET_CYC - 1);

    enc_state_t  state;
    logic [23:0] shreg;
    logic [4:0]  idx;
    logic        pending;
    logic        dout_q;
    logic        busy_q;
    logic        accept;
    logic        last_bit_end;

    ws2812_encoder_if #(.CNT_W(CNT_W)) tmr_if ();

    ws2812_phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .tmr   (tmr_if.slave)
    );

    assign last_bit_end  = (state == ST_LOW) && tmr_if.done && (idx == 5'd0);
    assign o_pixel_ready = (state == ST_IDLE) || (last_bit_end && !pending);
    assign accept        = i_pixel_valid && o_pixel_ready;
    assign o_dout        = dout_q;
    assign o_busy        = busy_q;

    always_comb begin
        tmr_if.load     = 1'b0;
        tmr_if.load_val = T0H_LD;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    tmr_if.load     = 1'b1;
                    tmr_if.load_val = i_pixel[23] ? T1H_LD : T0H_LD;
                end else if (i_latch) begin
                    tmr_if.load     = 1'b1;
                    tmr_if.load_val = TRST_LD;
                end
            end
            ST_HIGH: begin
                if (tmr_if.done) begin
                    tmr_if.load     = 1'b1;
                    tmr_if.load_val = shreg[23] ? T1L_LD : T0L_LD;
                end
            end
            ST_LOW: begin
                // shreg[22] is the next bit once this bit's shift takes effect.
                if (tmr_if.done) begin
                    if (idx != 5'd0) begin
                        tmr_if.load     = 1'b1;
                        tmr_if.load_val = shreg[22] ? T1H_LD : T0H_LD;
                    end else if (accept) begin
                        tmr_if.load     = 1'b1;
                        tmr_if.load_val = i_pixel[23] ? T1H_LD : T0H_LD;
                    end else if (pending || i_latch) begin
                        tmr_if.load     = 1'b1;
                        tmr_if.load_val = TRST_LD;
                    end
                end
            end
            ST_LATCH: begin
                tmr_if.load = 1'b0;
            end
            default: begin
                tmr_if.load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            idx     <= '0;
            pending <= 1'b0;
            dout_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        shreg  <= i_pixel;
                        idx    <= 5'd23;
                        state  <= ST_HIGH;
                        dout_q <= 1'b1;
                        busy_q <= 1'b1;
                    end else if (i_latch) begin
                        state  <= ST_LATCH;
                        busy_q <= 1'b1;
                    end
                end
                ST_HIGH: begin
                    pending <= pending | i_latch;
                    if (tmr_if.done) begin
                        state  <= ST_LOW;
                        dout_q <= 1'b0;
                    end
                end
                ST_LOW: begin
                    pending <= pending | i_latch;
                    if (tmr_if.done) begin
                        if (idx != 5'd0) begin
                            idx    <= idx - 5'd1;
                            shreg  <= {shreg[22:0], 1'b0};
                            state  <= ST_HIGH;
                            dout_q <= 1'b1;
                        end else if (accept) begin
                            shreg  <= i_pixel;
                            idx    <= 5'd23;
                            state  <= ST_HIGH;
                            dout_q <= 1'b1;
                        end else if (pending || i_latch) begin
                            state <= ST_LATCH;
                        end else begin
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                end
                ST_LATCH: begin
                    if (tmr_if.done) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        pending <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_encoder.sv
// Scoreboard bench for ws2812_encoder: stimulus queues expected pulse shapes, a monitor measures o_dout.
module tb_ws2812_encoder;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int TBIT = 63;
    localparam int TRST = 2500;
    localparam int WORD = 24 * TBIT;

    typedef struct {
        int high;
        int low;
    } pulse_t;

    logic        clk;
    logic        rst_n;
    logic [23:0] pixel;
    logic        valid;
    logic        ready;
    logic        latch;
    logic        dout;
    logic        busy;

    int tests = 0;
    int fails = 0;
    pulse_t sb[$];

    ws2812_encoder dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_pixel       (pixel),
        .i_pixel_valid (valid),
        .o_pixel_ready (ready),
        .i_latch       (latch),
        .o_dout        (dout),
        .o_busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: measure each high pulse and the low run that follows it
    pulse_t cur;
    logic   active = 1'b0;
    logic   prev   = 1'b0;
    int     high_run = 0;
    int     low_run  = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            active   = 1'b0;
            prev     = 1'b0;
            high_run = 0;
            low_run  = 0;
        end else begin
            if (dout && !prev) begin
                if (active && cur.low != 0) chk("low_len", low_run, cur.low);
                if (sb.size() == 0) begin
                    chk("unexpected_pulse", 1, 0);
                    active = 1'b0;
                end else begin
                    cur    = sb.pop_front();
                    active = 1'b1;
                end
                high_run = 1;
            end else if (dout) begin
                high_run++;
            end else if (prev) begin
                if (active) chk("high_len", high_run, cur.high);
                low_run = 1;
            end else begin
                low_run++;
            end
            prev = dout;
        end
    end

    task automatic accept(input logic [23:0] w, input bit chk_last_low, input bit with_latch,
                          output int waited);
        pulse_t p;
        int n = 0;
        @(negedge clk);
        pixel = w;
        valid = 1'b1;
        latch = with_latch;
        while (!ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", ready, 1);
        for (int i = 0; i < 24; i++) begin
            p.high = w[23-i] ? T1H : T0H;
            p.low  = (i == 23 && !chk_last_low) ? 0 : TBIT - p.high;
            sb.push_back(p);
        end
        @(posedge clk);
        #1;
        valid  = 1'b0;
        latch  = 1'b0;
        waited = n;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 8000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        int bad_r;
        int bad_d;
        rst_n = 1'b0;
        pixel = '0;
        valid = 1'b0;
        latch = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", ready, 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_release", ready, 1);

        // All-ones word: 40 high / 23 low per bit, busy for exactly one word
        accept(24'hFFFFFF, 1'b0, 1'b0, n);
        wait_idle(n);
        chk("busy_len_ffffff", n, WORD);
        repeat (3) @(negedge clk);
        chk("sb_empty_ffffff", sb.size(), 0);

        accept(24'h000000, 1'b0, 1'b0, n);
        wait_idle(n);
        chk("busy_len_000000", n, WORD);
        accept(24'h800001, 1'b0, 1'b0, n);
        wait_idle(n);
        chk("busy_len_800001", n, WORD);
        repeat (3) @(negedge clk);
        chk("sb_empty_800001", sb.size(), 0);

        // Back-to-back words: second accepted on the final cycle of the first
        accept(24'hA5A5A5, 1'b1, 1'b0, n);
        accept(24'h5A5A5A, 1'b0, 1'b0, n);
        chk("stream_ready_wait", n, WORD - 1);
        wait_idle(n);
        chk("busy_len_stream", n, WORD);
        repeat (3) @(negedge clk);
        chk("sb_empty_stream", sb.size(), 0);

        // Latch requested during bit 10: word completes, then a full latch gap
        accept(24'h123456, 1'b0, 1'b0, n);
        repeat (13 * TBIT + 5) @(negedge clk);
        latch = 1'b1;
        @(negedge clk);
        latch = 1'b0;
        bad_r = 0;
        bad_d = 0;
        for (int c = 13 * TBIT + 7; c <= WORD + TRST; c++) begin
            @(negedge clk);
            if (ready) bad_r++;
            if (c > WORD && dout) bad_d++;
        end
        chk("latch_ready_low_cycles", bad_r, 0);
        chk("latch_dout_high_cycles", bad_d, 0);
        @(negedge clk);
        chk("latch_end_ready", ready, 1);
        chk("latch_end_busy", busy, 0);
        chk("sb_empty_latch", sb.size(), 0);

        // Valid and latch together in idle: pixel wins, no latch gap
        accept(24'hF0F0F0, 1'b0, 1'b1, n);
        wait_idle(n);
        chk("busy_len_valid_latch", n, WORD);

        // Reset asserted during the high phase of bit 5
        accept(24'hC3C3C3, 1'b0, 1'b0, n);
        repeat (18 * TBIT + 2) @(negedge clk);
        chk("pre_reset_dout", dout, 1);
        #1;
        sb.delete();
        rst_n = 1'b0;
        #1;
        chk("midbit_rst_dout", dout, 0);
        chk("midbit_rst_busy", busy, 0);
        chk("midbit_rst_ready", ready, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ready, 1);
        chk("post_rst_dout", dout, 0);
        accept(24'h3C0F81, 1'b0, 1'b0, n);
        chk("post_rst_accept_wait", n, 0);
        wait_idle(n);
        chk("busy_len_post_rst", n, WORD);
        repeat (3) @(negedge clk);
        chk("sb_empty_final", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
